// File: rtl/transmisor_serial_if.sv
// Byte handshake and serial line bundle for transmisor_serial.
// master drives data/send; slave (the transmitter) drives ready/tx/busy.
interface transmisor_serial_if;
  logic [7:0] data_in;
  logic       send;
  logic       ready;
  logic       tx;
  logic       busy;

  modport master (
    output data_in,
    output send,
    input  ready,
    input  tx,
    input  busy
  );

  modport slave (
    input  data_in,
    input  send,
    output ready,
    output tx,
    output busy
  );
endinterface

// File: rtl/transmisor_serial.sv
// Serial frame transmitter: start, 8 data bits LSB first, even parity, stop.
// Define TRANSMISOR_FIFO_EN to place a FIFO_DEPTH-entry FIFO in front of the FSM.
module transmisor_serial #(
  parameter int unsigned TICKS_PER_BIT = 16
`ifdef TRANSMISOR_FIFO_EN
  ,
  parameter int unsigned FIFO_DEPTH    = 4
`endif
) (
  input  logic                clk,
  input  logic                rst,
  transmisor_serial_if.slave  bus_io
);

  localparam int unsigned TW = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
  localparam logic [TW-1:0] TickMax = TW'(TICKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;

  logic          avail;
  logic [7:0]    byte_in;
  logic          ready;
  logic          bit_end;

`ifdef TRANSMISOR_FIFO_EN
  localparam int unsigned PW = $clog2(FIFO_DEPTH);

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [PW:0]   cnt_q;
  logic          full, push, pop;

  assign full    = (cnt_q == (PW + 1)'(FIFO_DEPTH));
  assign ready   = !full;
  assign push    = bus_io.send && !full;
  assign avail   = (cnt_q != '0);
  assign byte_in = mem_q[rd_q];
  assign pop     = (state_q == StIdle) && avail;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= bus_io.data_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      // Simultaneous push and pop leaves the count unchanged.
      if (push && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (pop && !push) cnt_q <= cnt_q - 1'b1;
    end
  end
`else
  assign ready   = (state_q == StIdle);
  assign avail   = bus_io.send && ready;
  assign byte_in = bus_io.data_in;
`endif

  assign bit_end = (tick_q == TickMax);

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;

    if (state_q != StIdle) tick_d = bit_end ? '0 : tick_q + 1'b1;

    unique case (state_q)
      StIdle: begin
        if (avail) begin
          shift_d = byte_in;
          par_d   = ^byte_in;
          state_d = StStart;
        end
      end
      StStart: begin
        if (bit_end) state_d = StData;
      end
      StData: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            bit_d   = 3'd0;
            state_d = StParity;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      StParity: begin
        if (bit_end) state_d = StStop;
      end
      StStop: begin
        if (bit_end) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Line and busy are registered from the current state, so both lag the FSM by one cycle.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_q != StIdle);
    unique case (state_q)
      StIdle:   tx_d = 1'b1;
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shift_q[bit_q];
      StParity: tx_d = par_q;
      StStop:   tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      tick_q  <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  assign bus_io.ready = ready;
  assign bus_io.tx    = tx_q;
  assign bus_io.busy  = busy_q;

endmodule
